// File: rtl/laser_shot.sv
// laser_shot: player laser projectile.
// Launches one shot above the ship on a fire press, moves it up SPEED lines per
// frame, retires it on a hit or at the top of the screen, then waits COOLDOWN
// frames before the next launch is accepted. Drives a registered pixel color
// and the shot coordinates for collision logic.
// Optional build macro: LASER_AUTOFIRE_EN (a held fire level relaunches from IDLE).
//
// Handshakes: this block has no valid/ready interfaces. fire is a level from an
// asynchronous button, and hit is a single-cycle pulse that is acted on only in FLYING.
module laser_shot #(
    parameter int        SHIP_Y     = 435,
    parameter int        SHOT_W     = 2,
    parameter int        SHOT_H     = 8,
    parameter int        SPEED      = 4,
    parameter int        COOLDOWN   = 8,
    parameter logic [2:0] SHOT_COLOR = 3'b010,
    parameter int        FRAME_LINE = 480,
    parameter int        H_VISIBLE  = 640
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fire,
    input  logic [9:0] gunPosition,
    input  logic [9:0] hPos,
    input  logic [9:0] vPos,
    input  logic       hit,
    output logic [9:0] shotX,
    output logic [9:0] shotY,
    output logic       shotActive,
    output logic [2:0] color,
    output logic [1:0] state
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_FLYING   = 2'd1;
    localparam logic [1:0] S_COOLDOWN = 2'd2;

    localparam logic [9:0] LAUNCH_Y   = 10'(SHIP_Y - SHOT_H);
    localparam logic [9:0] X_MAX      = 10'(H_VISIBLE - SHOT_W);
    localparam logic [9:0] SPEED_V    = 10'(SPEED);
    localparam logic [9:0] FRAME_V    = 10'(FRAME_LINE);
    localparam logic [7:0] CD_INIT    = 8'(COOLDOWN);
    localparam logic [10:0] SHOT_W_V  = 11'(SHOT_W);
    localparam logic [10:0] SHOT_H_V  = 11'(SHOT_H);

    logic       fire_meta;
    logic       fire_sync;
    logic       fire_prev;
    logic       fire_pulse;
    logic       at_line;
    logic       at_line_q;
    logic       frame_tick;
    logic       launch_req;
    logic [7:0] cd_cnt;
    logic [9:0] launch_x;
    logic       in_x;
    logic       in_y;

    // Two-flop synchronizer for the button plus a registered rising-edge pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fire_meta  <= 1'b0;
            fire_sync  <= 1'b0;
            fire_prev  <= 1'b0;
            fire_pulse <= 1'b0;
        end else begin
            fire_meta  <= fire;
            fire_sync  <= fire_meta;
            fire_prev  <= fire_sync;
            fire_pulse <= fire_sync & ~fire_prev;
        end
    end

    // Remember the previous scan-position match so the tick fires only on entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            at_line_q <= 1'b0;
        end else begin
            at_line_q <= at_line;
        end
    end

    // Frame tick, launch request, clamped launch column and pixel-window tests.
    always_comb begin
        at_line    = (hPos == 10'd0) && (vPos == FRAME_V);
        frame_tick = at_line & ~at_line_q;
`ifdef LASER_AUTOFIRE_EN
        launch_req = fire_sync;
`else
        launch_req = fire_pulse;
`endif
        launch_x   = (gunPosition > X_MAX) ? X_MAX : gunPosition;
        in_x       = ({1'b0, hPos} >= {1'b0, shotX}) &&
                     ({1'b0, hPos} <  ({1'b0, shotX} + SHOT_W_V));
        in_y       = ({1'b0, vPos} >= {1'b0, shotY}) &&
                     ({1'b0, vPos} <  ({1'b0, shotY} + SHOT_H_V));
    end

    // Shot state machine: launch, per-frame motion, retirement and cooldown.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            shotX      <= 10'd0;
            shotY      <= LAUNCH_Y;
            shotActive <= 1'b0;
            cd_cnt     <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch_req) begin
                        shotX      <= launch_x;
                        shotY      <= LAUNCH_Y;
                        shotActive <= 1'b1;
                        state      <= S_FLYING;
                    end
                end
                S_FLYING: begin
                    // A hit wins over a same-cycle tick; a shot too close to
                    // the top retires instead of wrapping around.
                    if (hit || (frame_tick && (shotY < SPEED_V))) begin
                        shotActive <= 1'b0;
                        cd_cnt     <= CD_INIT;
                        state      <= S_COOLDOWN;
                    end else if (frame_tick) begin
                        shotY <= shotY - SPEED_V;
                    end
                end
                S_COOLDOWN: begin
                    if (cd_cnt == 8'd0) begin
                        state <= S_IDLE;
                    end else if (frame_tick) begin
                        if (cd_cnt == 8'd1) begin
                            state <= S_IDLE;
                        end
                        cd_cnt <= cd_cnt - 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Registered pixel color: one clock behind the scan position.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            color <= 3'b000;
        end else if (shotActive && in_x && in_y) begin
            color <= SHOT_COLOR;
        end else begin
            color <= 3'b000;
        end
    end

endmodule
